// File: rtl/fu_issue_arbiter.sv
// fu_issue_arbiter: per-FU round-robin select of ready issue-queue entries, issued with valid/ready.
// Define ISSUE_BACK_TO_BACK_EN to reselect in the fire cycle for 1 issue/cycle per FU.
module fu_issue_arbiter #(
    parameter int NUM_ENTRIES = 64,
    parameter int NUM_FU      = 3,
    parameter int IDX_W       = 6,
    parameter int TYPE_W      = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic [NUM_ENTRIES-1:0]        entry_ready,
    input  logic [NUM_ENTRIES*TYPE_W-1:0] entry_fu_type,
    input  logic [NUM_FU-1:0]             fu_ready,
    output logic [NUM_FU-1:0]             issue_valid,
    output logic [NUM_FU*IDX_W-1:0]       issue_idx,
    output logic [NUM_FU-1:0]             issue_fire
);
    typedef enum logic {IDLE, GRANT} state_t;

    // First set bit of v at or after start, wrapping at NUM_ENTRIES.
    function automatic logic [IDX_W-1:0] pick(input logic [NUM_ENTRIES-1:0] v, input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] r;
        logic found;
        int j;
        r = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            j = (int'(start) + k) % NUM_ENTRIES;
            if (!found && v[j]) begin
                r = IDX_W'(j);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    genvar f;
    generate
        for (f = 0; f < NUM_FU; f++) begin : g_fu
            state_t state_q, state_d;
            logic [IDX_W-1:0] idx_q, idx_d, ptr_q, ptr_d, nxt_idx;
            logic [NUM_ENTRIES-1:0] elig;
`ifdef ISSUE_BACK_TO_BACK_EN
            logic [NUM_ENTRIES-1:0] rest;
`endif

            assign issue_valid[f] = state_q == GRANT;
            assign issue_idx[f*IDX_W +: IDX_W] = idx_q;
            assign issue_fire[f] = issue_valid[f] & fu_ready[f] & ~flush;
            assign nxt_idx = (idx_q == IDX_W'(NUM_ENTRIES-1)) ? '0 : idx_q + IDX_W'(1);

            always_comb begin
                for (int i = 0; i < NUM_ENTRIES; i++)
                    elig[i] = entry_ready[i] && entry_fu_type[i*TYPE_W +: TYPE_W] == TYPE_W'(f);
            end

            always_comb begin
                state_d = state_q;
                idx_d = idx_q;
                ptr_d = ptr_q;
`ifdef ISSUE_BACK_TO_BACK_EN
                rest = elig;
                rest[idx_q] = 1'b0;
`endif
                if (flush) begin
                    state_d = IDLE;
                end else if (state_q == IDLE) begin
                    state_d = |elig ? GRANT : IDLE;
                    idx_d = |elig ? pick(elig, ptr_q) : idx_q;
                end else if (issue_fire[f]) begin
                    ptr_d = nxt_idx;
`ifdef ISSUE_BACK_TO_BACK_EN
                    // The fired entry is still marked ready this cycle, so it is masked out.
                    state_d = |rest ? GRANT : IDLE;
                    idx_d = |rest ? pick(rest, nxt_idx) : idx_q;
`else
                    state_d = IDLE;
`endif
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    state_q <= IDLE;
                    idx_q <= '0;
                    ptr_q <= '0;
                end else begin
                    state_q <= state_d;
                    idx_q <= idx_d;
                    ptr_q <= ptr_d;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_fu_issue_arbiter.sv
// tb_fu_issue_arbiter: directed vectors and corner sequences for fu_issue_arbiter.
module tb_fu_issue_arbiter;
    logic clk = 1'b0;
    logic reset_n, flush;
    logic [63:0] entry_ready;
    logic [127:0] entry_fu_type;
    logic [2:0] fu_ready, issue_valid, issue_fire;
    logic [17:0] issue_idx;
    int n_vec = 0;
    int n_miss = 0;
    int fire_idx[$];
    int fire_cyc[$];

    fu_issue_arbiter dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .entry_ready(entry_ready),
        .entry_fu_type(entry_fu_type), .fu_ready(fu_ready), .issue_valid(issue_valid),
        .issue_idx(issue_idx), .issue_fire(issue_fire)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] ready;
        int mode;
        logic [2:0] fr;
        logic [2:0] ev;
        logic [17:0] ei;
        logic [2:0] ef;
    } vec_t;
    vec_t tv [9];

    // mode 0: type i%3, 1: type i%4, 2: all type 0, 3: all type 2
    function automatic logic [127:0] tgen(input int m);
        logic [127:0] t;
        t = '0;
        for (int i = 0; i < 64; i++)
            t[i*2 +: 2] = (m == 0) ? 2'(i % 3) : (m == 1) ? 2'(i % 4) : (m == 2) ? 2'd0 : 2'd2;
        return t;
    endfunction

    function automatic logic [5:0] getidx(input int f);
        return issue_idx[f*6 +: 6];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        flush = 1'b0;
        fu_ready = '0;
        entry_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles, modelling the queue clearing each fired entry on the fire edge.
    task automatic run_q(input int f, input int n);
        logic pend;
        logic [5:0] p;
        pend = 1'b0;
        p = '0;
        fire_idx.delete();
        fire_cyc.delete();
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (pend) entry_ready[p] = 1'b0;
            pend = 1'b0;
            #1;
            if (issue_fire[f]) begin
                p = getidx(f);
                pend = 1'b1;
                fire_idx.push_back(int'(p));
                fire_cyc.push_back(c);
            end
        end
        @(posedge clk);
        #1;
        if (pend) entry_ready[p] = 1'b0;
    endtask

    initial begin
        tv[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 0, 3'b000, 3'b111, {6'd2, 6'd1, 6'd0}, 3'b000};
        tv[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 0, 3'b111, 3'b111, {6'd2, 6'd1, 6'd0}, 3'b111};
        tv[2] = '{64'h0, 0, 3'b111, 3'b000, 18'd0, 3'b000};
        tv[3] = '{(64'd1 << 3) | (64'd1 << 7) | (64'd1 << 11), 1, 3'b111, 3'b000, 18'd0, 3'b000};
        tv[4] = '{(64'd1 << 3) | (64'd1 << 7) | (64'd1 << 10), 1, 3'b100, 3'b100, {6'd10, 6'd0, 6'd0}, 3'b100};
        tv[5] = '{(64'd1 << 5) | (64'd1 << 9) | (64'd1 << 63), 0, 3'b011, 3'b101, {6'd5, 6'd0, 6'd9}, 3'b001};
        tv[6] = '{64'd1 << 63, 3, 3'b100, 3'b100, {6'd63, 6'd0, 6'd0}, 3'b100};
        tv[7] = '{(64'd1 << 62) | (64'd1 << 63), 1, 3'b000, 3'b100, {6'd62, 6'd0, 6'd0}, 3'b000};
        tv[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 2, 3'b111, 3'b001, 18'd0, 3'b001};

        reset_n = 1'b0;
        flush = 1'b0;
        fu_ready = 3'b111;
        entry_ready = '1;
        entry_fu_type = tgen(0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_valid", 64'(issue_valid), 64'd0);
            chk("rst_idx", 64'(issue_idx), 64'd0);
            chk("rst_fire", 64'(issue_fire), 64'd0);
        end
        reset_n = 1'b1;
        fu_ready = '0;
        tick();
        chk("rel_valid", 64'(issue_valid), 64'b111);
        chk("rel_idx", 64'(issue_idx), 64'({6'd2, 6'd1, 6'd0}));

        for (int v = 0; v < 9; v++) begin
            do_reset();
            entry_ready = tv[v].ready;
            entry_fu_type = tgen(tv[v].mode);
            fu_ready = tv[v].fr;
            tick();
            chk($sformatf("v%0d_valid", v), 64'(issue_valid), 64'(tv[v].ev));
            chk($sformatf("v%0d_idx", v), 64'(issue_idx), 64'(tv[v].ei));
            chk($sformatf("v%0d_fire", v), 64'(issue_fire), 64'(tv[v].ef));
        end

        do_reset();
        entry_fu_type = tgen(1);
        entry_ready = 64'd1 << 5;
        fu_ready = 3'b010;
        tick();
        chk("single_valid", 64'(issue_valid), 64'b010);
        chk("single_idx", 64'(getidx(1)), 64'd5);
        chk("single_fire", 64'(issue_fire), 64'b010);
        tick();
        entry_ready = (64'd1 << 1) | (64'd1 << 9);
        fu_ready = '0;
        #1;
        chk("single_after_valid", 64'(issue_valid), 64'd0);
        tick();
        chk("single_ptr_valid", 64'(issue_valid), 64'b010);
        chk("single_ptr_idx", 64'(getidx(1)), 64'd9);

        do_reset();
        entry_fu_type = tgen(2);
        entry_ready = (64'd1 << 2) | (64'd1 << 40) | (64'd1 << 63);
        fu_ready = 3'b001;
        run_q(0, 10);
        chk("wrap_count", 64'(fire_idx.size()), 64'd3);
        chk("wrap_first", 64'((fire_idx.size() > 0) ? fire_idx[0] : -1), 64'd2);
        chk("wrap_second", 64'((fire_idx.size() > 1) ? fire_idx[1] : -1), 64'd40);
        chk("wrap_third", 64'((fire_idx.size() > 2) ? fire_idx[2] : -1), 64'd63);
        entry_ready = (64'd1 << 2) | (64'd1 << 40);
        fu_ready = '0;
        tick();
        chk("wrap_regrant_valid", 64'(issue_valid), 64'b001);
        chk("wrap_regrant_idx", 64'(getidx(0)), 64'd2);

        do_reset();
        entry_fu_type = tgen(3);
        entry_ready = 64'd1 << 7;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", 64'(issue_valid), 64'b100);
            chk("stall_idx", 64'(getidx(2)), 64'd7);
            chk("stall_fire", 64'(issue_fire), 64'd0);
            tick();
        end
        fu_ready = 3'b100;
        #1;
        chk("stall_release_fire", 64'(issue_fire), 64'b100);
        tick();
        entry_ready = '0;
        #1;
        chk("stall_after_valid", 64'(issue_valid), 64'd0);
        chk("stall_after_fire", 64'(issue_fire), 64'd0);

        do_reset();
        entry_fu_type = tgen(3);
        entry_ready = (64'd1 << 7) | (64'd1 << 20);
        tick();
        chk("flush_grant_idx", 64'(getidx(2)), 64'd7);
        fu_ready = 3'b100;
        flush = 1'b1;
        #1;
        chk("flush_fire", 64'(issue_fire), 64'd0);
        tick();
        flush = 1'b0;
        fu_ready = '0;
        #1;
        chk("flush_valid", 64'(issue_valid), 64'd0);
        tick();
        chk("flush_regrant_valid", 64'(issue_valid), 64'b100);
        chk("flush_ptr_idx", 64'(getidx(2)), 64'd7);

        do_reset();
        entry_fu_type = tgen(2);
        entry_ready = (64'd1 << 1) | (64'd1 << 3);
        fu_ready = 3'b001;
        run_q(0, 6);
        chk("b2b_count", 64'(fire_idx.size()), 64'd2);
        chk("b2b_first", 64'((fire_idx.size() > 0) ? fire_idx[0] : -1), 64'd1);
        chk("b2b_second", 64'((fire_idx.size() > 1) ? fire_idx[1] : -1), 64'd3);
`ifdef ISSUE_BACK_TO_BACK_EN
        chk("b2b_gap", 64'((fire_cyc.size() > 1) ? fire_cyc[1] - fire_cyc[0] : -1), 64'd1);
`else
        chk("b2b_gap", 64'((fire_cyc.size() > 1) ? fire_cyc[1] - fire_cyc[0] : -1), 64'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
